acc_control_unit: RTL and testbench

- Multi-cycle control FSM for the 11-bit accumulator datapath.
- Latches the opcode of each fetched instruction and sequences the datapath through FETCH/DECODE/EXEC.
- Drives the accumulator input mux select `sel_A`, the accumulator write enable, the ALU operation, PC and IR strobes, and the data-memory write.
- Sits between instruction memory and the accumulator/ALU/data-memory datapath.

---
 rtl/acc_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_acc_control_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_control_unit.sv
// acc_control_unit: FETCH/DECODE/EXEC sequencer for the 11-bit accumulator datapath.
// Latency: 3 cycles per instruction; HLT reaches HALT 2 cycles after FETCH; first FETCH 1 cycle after start.
// Backpressure: none, datapath strobes are decoded every cycle. ILLEGAL_OP_TRAP_EN enables the illegal-opcode trap.
module acc_control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  zero_flag,
  output logic [1:0]            sel_A,
  output logic                  wr_A,
  output logic                  sel_B,
  output logic [2:0]            alu_op,
  output logic                  ir_wr,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  mem_wr,
  output logic                  busy,
  output logic                  halted
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ST   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(13);

  localparam logic [1:0] SELA_ALU = 2'b00;
  localparam logic [1:0] SELA_EXT = 2'b01;
  localparam logic [1:0] SELA_MEM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [OPCODE_WIDTH-1:0] fetched_opcode;
  logic                    opcode_legal;

  // Operand bits belong to the IR/extender path, not to the sequencer.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction[DATA_WIDTH-OPCODE_WIDTH-1:0];

  assign fetched_opcode = instruction[DATA_WIDTH-1 -: OPCODE_WIDTH];

  // Legal opcodes are the contiguous range HLT..NOP.
  assign opcode_legal = (opcode_q <= OP_NOP);

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_op = illegal_q;
`endif

  // Next-state and opcode-latch decision.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        opcode_d = fetched_opcode;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (opcode_q == OP_HLT) begin
          state_d = S_HALT;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        else if (!opcode_legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
`endif
        else begin
          // Without the trap, illegal opcodes fall through EXEC with no strobes.
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        // Only reset leaves HALT; start is deliberately ignored.
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and opcode registers; reset also aborts an instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Moore decode of datapath strobes; zero_flag only gates pc_load in EXEC.
  always_comb begin
    sel_A   = SELA_ALU;
    wr_A    = 1'b0;
    sel_B   = 1'b0;
    alu_op  = ALU_ADD;
    ir_wr   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    mem_wr  = 1'b0;
    busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    halted  = (state_q == S_HALT);

    case (state_q)
      S_FETCH: begin
        ir_wr  = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_LDI: begin
            sel_A = SELA_EXT;
            wr_A  = 1'b1;
          end
          OP_LD: begin
            sel_A = SELA_MEM;
            wr_A  = 1'b1;
          end
          OP_ST: begin
            mem_wr = 1'b1;
          end
          OP_ADD, OP_ADDI: begin
            alu_op = ALU_ADD;
            sel_B  = (opcode_q == OP_ADDI);
            wr_A   = 1'b1;
          end
          OP_SUB, OP_SUBI: begin
            alu_op = ALU_SUB;
            sel_B  = (opcode_q == OP_SUBI);
            wr_A   = 1'b1;
          end
          OP_AND: begin
            alu_op = ALU_AND;
            wr_A   = 1'b1;
          end
          OP_OR: begin
            alu_op = ALU_OR;
            wr_A   = 1'b1;
          end
          OP_BEQ: begin
            pc_load = zero_flag;
          end
          OP_BNE: begin
            pc_load = !zero_flag;
          end
          OP_JMP: begin
            pc_load = 1'b1;
          end
          default: begin
            // NOP and untrapped illegal opcodes: no strobes.
          end
        endcase
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// tb_acc_control_unit: directed table, hand sequences and random instruction stream for acc_control_unit.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_acc_control_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [10:0] instruction;
  logic        zero_flag;
  logic [1:0]  sel_A;
  logic        wr_A;
  logic        sel_B;
  logic [2:0]  alu_op;
  logic        ir_wr;
  logic        pc_inc;
  logic        pc_load;
  logic        mem_wr;
  logic        busy;
  logic        halted;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  int vectors     = 0;
  int miscompares = 0;

  acc_control_unit #(.DATA_WIDTH(11), .OPCODE_WIDTH(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .instruction (instruction),
    .zero_flag   (zero_flag),
    .sel_A       (sel_A),
    .wr_A        (wr_A),
    .sel_B       (sel_B),
    .alu_op      (alu_op),
    .ir_wr       (ir_wr),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .mem_wr      (mem_wr),
    .busy        (busy),
    .halted      (halted)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .illegal_op  (illegal_op)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector layout: {sel_A[1:0], wr_A, sel_B, alu_op[2:0], ir_wr, pc_inc, pc_load, mem_wr, busy, halted}
  localparam logic [13:0] EXP_ZERO   = 14'b00_0_0_000_0_0_0_0_0_0;
  localparam logic [13:0] EXP_FETCH  = 14'b00_0_0_000_1_1_0_0_1_0;
  localparam logic [13:0] EXP_DECODE = 14'b00_0_0_000_0_0_0_0_1_0;
  localparam logic [13:0] EXP_HALT   = 14'b00_0_0_000_0_0_0_0_0_1;

  typedef struct {
    string       name;
    logic [10:0] instr;
    bit          zf;
    logic [13:0] exp_exec;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] got();
    return {sel_A, wr_A, sel_B, alu_op, ir_wr, pc_inc, pc_load, mem_wr, busy, halted};
  endfunction

  // Reference: EXEC-cycle strobes derived from the opcode list arithmetically.
  function automatic logic [13:0] model_exec(input int op, input bit zf);
    logic [1:0] sa;
    bit         wa, sb, pl, mw;
    logic [2:0] alu;
    sa = 2'b00; wa = 0; sb = 0; pl = 0; mw = 0; alu = 3'b000;
    if (op == 1) begin
      sa = 2'b01; wa = 1;
    end else if (op == 2) begin
      sa = 2'b10; wa = 1;
    end else if (op == 3) begin
      mw = 1;
    end else if (op >= 4 && op <= 9) begin
      wa  = 1;
      sb  = (op < 8) && (op % 2 == 1);
      alu = 3'((op < 8) ? (op - 4) / 2 : op - 6);
    end else if (op == 10) begin
      pl = zf;
    end else if (op == 11) begin
      pl = !zf;
    end else if (op == 12) begin
      pl = 1;
    end
    return {sa, wa, sb, alu, 1'b0, 1'b0, pl, mw, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] g;
    g = got();
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, g, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, then move just past the rising edge.
  task automatic cyc(input string name, input logic [13:0] exp);
    @(negedge clock);
    check(name, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b1;
    instruction = '0;
    zero_flag   = 1'b0;

    tbl.push_back('{"ldi",      11'b00001_110001, 1'b0, 14'b01_1_0_000_0_0_0_0_1_0});
    tbl.push_back('{"ld",       11'b00010_000100, 1'b0, 14'b10_1_0_000_0_0_0_0_1_0});
    tbl.push_back('{"st",       11'b00011_000111, 1'b1, 14'b00_0_0_000_0_0_0_1_1_0});
    tbl.push_back('{"add",      11'b00100_000001, 1'b0, 14'b00_1_0_000_0_0_0_0_1_0});
    tbl.push_back('{"addi",     11'b00101_000011, 1'b0, 14'b00_1_1_000_0_0_0_0_1_0});
    tbl.push_back('{"sub",      11'b00110_000010, 1'b1, 14'b00_1_0_001_0_0_0_0_1_0});
    tbl.push_back('{"subi",     11'b00111_000010, 1'b0, 14'b00_1_1_001_0_0_0_0_1_0});
    tbl.push_back('{"and",      11'b01000_000101, 1'b0, 14'b00_1_0_010_0_0_0_0_1_0});
    tbl.push_back('{"or",       11'b01001_000101, 1'b1, 14'b00_1_0_011_0_0_0_0_1_0});
    tbl.push_back('{"beq_z1",   11'b01010_001000, 1'b1, 14'b00_0_0_000_0_0_1_0_1_0});
    tbl.push_back('{"beq_z0",   11'b01010_001000, 1'b0, 14'b00_0_0_000_0_0_0_0_1_0});
    tbl.push_back('{"bne_z0",   11'b01011_001001, 1'b0, 14'b00_0_0_000_0_0_1_0_1_0});
    tbl.push_back('{"bne_z1",   11'b01011_001001, 1'b1, 14'b00_0_0_000_0_0_0_0_1_0});
    tbl.push_back('{"jmp_z0",   11'b01100_111111, 1'b0, 14'b00_0_0_000_0_0_1_0_1_0});
    tbl.push_back('{"jmp_z1",   11'b01100_111111, 1'b1, 14'b00_0_0_000_0_0_1_0_1_0});
    tbl.push_back('{"nop",      11'b01101_000000, 1'b1, 14'b00_0_0_000_0_0_0_0_1_0});
`ifndef ILLEGAL_OP_TRAP_EN
    tbl.push_back('{"ill_nop",  11'b11111_000000, 1'b1, 14'b00_0_0_000_0_0_0_0_1_0});
`endif

    // Reset held with start high: everything quiet.
    cyc("rst_start_hi_0", EXP_ZERO);
    cyc("rst_start_hi_1", EXP_ZERO);
    reset_n = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 3; i++) cyc("idle_no_start", EXP_ZERO);
    start = 1'b1;
    cyc("idle_start_sampled", EXP_ZERO);
    start = 1'b0;

    // Directed table: each entry runs FETCH, DECODE, EXEC back to back.
    foreach (tbl[k]) begin
      instruction = tbl[k].instr;
      zero_flag   = tbl[k].zf;
      cyc({tbl[k].name, "_fetch"}, EXP_FETCH);
      instruction = 11'($urandom);
      cyc({tbl[k].name, "_decode"}, EXP_DECODE);
      cyc({tbl[k].name, "_exec"}, tbl[k].exp_exec);
    end

    // Random instruction stream with start toggling (ignored while busy).
    for (int n = 0; n < 300; n++) begin
      int op;
      bit zf;
`ifdef ILLEGAL_OP_TRAP_EN
      op = $urandom_range(1, 13);
`else
      op = $urandom_range(1, 31);
`endif
      zf          = 1'($urandom);
      zero_flag   = zf;
      start       = 1'($urandom);
      instruction = {5'(op), 6'($urandom)};
      cyc("rand_fetch", EXP_FETCH);
      instruction = 11'($urandom);
      start       = 1'($urandom);
      cyc("rand_decode", EXP_DECODE);
      start       = 1'($urandom);
      cyc($sformatf("rand_exec_op%0d_zf%0d", op, zf), model_exec(op, zf));
    end
    start = 1'b0;

    // HLT: HALT two cycles after FETCH, sticky across start pulses.
    instruction = 11'b00000_000000;
    cyc("hlt_fetch", EXP_FETCH);
    cyc("hlt_decode", EXP_DECODE);
    for (int i = 0; i < 4; i++) begin
      start = 1'(i % 2);
      cyc("hlt_sticky", EXP_HALT);
    end
    start   = 1'b0;
    reset_n = 1'b0;
    cyc("hlt_reset", EXP_ZERO);
    reset_n = 1'b1;
    start   = 1'b1;
    cyc("restart_idle", EXP_ZERO);
    start = 1'b0;

    // ST interrupted by reset in EXEC: mem_wr must drop without a clock edge.
    instruction = 11'b00011_000001;
    cyc("st_fetch", EXP_FETCH);
    cyc("st_decode", EXP_DECODE);
    @(negedge clock);
    check("st_exec", 14'b00_0_0_000_0_0_0_1_1_0);
    #1 reset_n = 1'b0;
    #1 check("st_async_reset", EXP_ZERO);
    @(posedge clock);
    #1;
    cyc("st_reset_hold", EXP_ZERO);
    reset_n = 1'b1;
    cyc("st_after_reset_idle", EXP_ZERO);
    start = 1'b1;
    cyc("st_restart_start", EXP_ZERO);
    start = 1'b0;

    // Illegal opcode 11111.
    instruction = 11'b11111_000000;
    cyc("ill_fetch", EXP_FETCH);
    cyc("ill_decode", EXP_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ill_halt", EXP_HALT);
      vectors++;
      if (illegal_op !== 1'b1) begin
        miscompares++;
        $display("FAIL ill_flag: got %b expected 1", illegal_op);
      end
      @(posedge clock);
      #1;
    end
`else
    cyc("ill_exec_nop", EXP_DECODE);
    instruction = 11'b00001_000000;
    cyc("ill_next_fetch", EXP_FETCH);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
